conv_acc9: RTL and testbench

//  Consumer end of the 9-product dot interface. Takes the nine signed 16-bit
//  per-tap products of one 3x3 window per input beat and sums them through a

---
 rtl/conv_acc9.sv | 162 ++++++++++++++++
 tb/tb_conv_acc9.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc9.sv
// conv_acc9: consumer end of the 9-product dot interface.
// Sums nine signed 16-bit tap products per beat through a two-level adder tree.
// Accumulates CIN beats on top of a bias, then requantizes to int8.
// Requantization applies round-half-up, an arithmetic shift, optional ReLU and saturation.
module conv_acc9 #(
    parameter int unsigned CIN   = 4,
    parameter int unsigned SHIFT = 7,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned RELU  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      dot0,
    input  logic [15:0]      dot1,
    input  logic [15:0]      dot2,
    input  logic [15:0]      dot3,
    input  logic [15:0]      dot4,
    input  logic [15:0]      dot5,
    input  logic [15:0]      dot6,
    input  logic [15:0]      dot7,
    input  logic [15:0]      dot8,
    input  logic [ACC_W-1:0] bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       ch_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(CIN - 1);
    localparam logic [ACC_W-1:0] RND =
        (SHIFT > 0) ? (ACC_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    logic                     en;
    logic                     beat;
    logic                     first;
    logic                     last;

    logic                     s1_valid;
    logic                     s1_first;
    logic                     s1_last;
    logic signed [17:0]       s1_p0;
    logic signed [17:0]       s1_p1;
    logic signed [17:0]       s1_p2;
    logic [ACC_W-1:0]         s1_bias;

    logic                     s2_valid;
    logic                     s2_last;
    logic [ACC_W-1:0]         acc;

    logic signed [19:0]       sum;
    logic [ACC_W-1:0]         acc_n;
    logic signed [ACC_W-1:0]  r_shift;
    logic signed [ACC_W-1:0]  r_relu;
    logic [7:0]               q;

    function automatic logic signed [17:0] add3(input logic [15:0] a,
                                                input logic [15:0] b,
                                                input logic [15:0] c);
        return 18'($signed(a)) + 18'($signed(b)) + 18'($signed(c));
    endfunction

    // Handshake, group position, S2 sum and requantization of the accumulator
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en && !clr;
        beat     = in_valid && in_ready;
        first    = (ch_cnt == 8'd0);
        last     = (ch_cnt == LAST_IDX);
        sum      = 20'(s1_p0) + 20'(s1_p1) + 20'(s1_p2);
        acc_n    = (s1_first ? s1_bias : acc) + ACC_W'(sum);
        // acc already holds acc_n of the beat now in S2, so S3 requantizes from acc
        r_shift  = $signed(acc + RND) >>> SHIFT;
        r_relu   = r_shift;
        if ((RELU != 0) && r_shift[ACC_W-1]) begin
            r_relu = '0;
        end
        if (r_relu > SAT_HI) begin
            q = 8'h7F;
        end else if (r_relu < SAT_LO) begin
            q = 8'h80;
        end else begin
            q = r_relu[7:0];
        end
    end

    // Beat index within the current group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
        end else if (clr) begin
            ch_cnt <= '0;
        end else if (beat) begin
            ch_cnt <= last ? 8'd0 : ch_cnt + 8'd1;
        end
    end

    // S1: three 3-tap partial sums, with group flags and bias riding along
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_p0    <= '0;
            s1_p1    <= '0;
            s1_p2    <= '0;
            s1_bias  <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= beat;
            if (beat) begin
                s1_first <= first;
                s1_last  <= last;
                s1_p0    <= add3(dot0, dot1, dot2);
                s1_p1    <= add3(dot3, dot4, dot5);
                s1_p2    <= add3(dot6, dot7, dot8);
                s1_bias  <= bias;
            end
        end
    end

    // S2: final tree level and channel accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                acc <= acc_n;
            end
        end
    end

    // S3: output register, loaded only by last beats and held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                out_acc  <= acc;
                out_data <= q;
            end
        end
    end

endmodule

// File: tb/tb_conv_acc9.sv
// Directed self-checking bench for conv_acc9.
// Four instances cover the parameter sets: 0 CIN1/SH0/noReLU, 1 CIN4/SH7/ReLU, 2 CIN1/SH0/ReLU, 3 CIN1/SH2/noReLU.
module tb_conv_acc9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        ordy;
    logic [3:0]  iv;
    logic [15:0] dotv;
    logic [31:0] biasv;
    logic [3:0]  ov;
    logic [3:0]  ir;
    logic [7:0]  od [4];
    logic [7:0]  cc [4];
    logic [31:0] oa [4];

    int ncmp  = 0;
    int nfail = 0;

    int sent;
    int got;
    int stall;
    bit seen;
    bit just_seen;
    logic [7:0]  held_d;
    logic [31:0] held_a;
    int exp_acc [2];
    int exp_dat [2];
    int n;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        conv_acc9 #(
            .CIN   ((g == 1) ? 4 : 1),
            .SHIFT ((g == 1) ? 7 : ((g == 3) ? 2 : 0)),
            .ACC_W (32),
            .RELU  ((g == 1 || g == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .dot0      (dotv),
            .dot1      (dotv),
            .dot2      (dotv),
            .dot3      (dotv),
            .dot4      (dotv),
            .dot5      (dotv),
            .dot6      (dotv),
            .dot7      (dotv),
            .dot8      (dotv),
            .bias      (biasv),
            .out_valid (ov[g]),
            .out_ready (ordy),
            .out_data  (od[g]),
            .out_acc   (oa[g]),
            .ch_cnt    (cc[g])
        );
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge; return at the negedge after it is accepted.
    task automatic send(input int i, input int d, input int b);
        int k = 0;
        dotv  = d[15:0];
        biasv = b;
        iv[i] = 1'b1;
        #1;
        while (!ir[i] && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("send_accept_timeout", (k < 20), 1);
        @(negedge clk);
        iv[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, input int eacc, input int edat, input string tag);
        int k = 0;
        while (!ov[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, (k < 20), 1);
        check({tag, "_acc"}, oa[i], eacc);
        check({tag, "_data"}, $signed(od[i]), edat);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        ordy  = 1'b1;
        iv    = '0;
        dotv  = '0;
        biasv = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_out_valid", ov[i], 0);
            check("rst_out_data", $signed(od[i]), 0);
            check("rst_out_acc", oa[i], 0);
            check("rst_ch_cnt", cc[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ir, 15);

        // all ones, latency of two edges after acceptance
        send(0, 1, 0);
        check("t1_lat_k", ov[0], 0);
        @(negedge clk);
        check("t1_lat_k1", ov[0], 0);
        @(negedge clk);
        check("t1_lat_k2", ov[0], 1);
        check("t1_acc", oa[0], 9);
        check("t1_data", $signed(od[0]), 9);
        @(negedge clk);
        check("t1_consumed", ov[0], 0);

        // saturation both ways, with and without ReLU
        send(0, 16384, 0);
        wait_out(0, 147456, 127, "t3_pos_sat");
        send(0, -16256, 0);
        wait_out(0, -146304, -128, "t3_neg_sat");
        send(2, -16256, 0);
        wait_out(2, -146304, 0, "t3_neg_relu");

        // round-half-up with SHIFT=2
        send(3, 0, -6);
        wait_out(3, -6, -1, "t6_m6");
        send(3, 0, 6);
        wait_out(3, 6, 2, "t6_p6");
        send(3, 0, 5);
        wait_out(3, 5, 1, "t6_p5");
        send(3, 0, -5);
        wait_out(3, -5, -1, "t6_m5");

        // CIN=4 group, bias after the first beat is ignored
        send(1, 100, 50);
        send(1, 100, 12345);
        check("t2_ch_cnt_mid", cc[1], 2);
        send(1, 100, 12345);
        send(1, 100, 12345);
        check("t2_ch_cnt_wrap", cc[1], 0);
        wait_out(1, 3650, 29, "t2_group");

        // 8-beat burst, first result held 5 cycles
        exp_acc[0] = 3650; exp_dat[0] = 29;
        exp_acc[1] = 7100; exp_dat[1] = 55;
        sent = 0; got = 0; stall = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || got < 2); cyc++) begin
            @(negedge clk);
            just_seen = 1'b0;
            if (ov[1] && !seen) begin
                seen      = 1'b1;
                just_seen = 1'b1;
                stall     = 5;
                held_d    = od[1];
                held_a    = oa[1];
            end
            ordy = (stall == 0);
            if (stall > 0) stall--;
            if (sent < 8) begin
                iv[1] = 1'b1;
                dotv  = (sent < 4) ? 16'd100 : 16'd200;
                biasv = (sent == 0) ? 32'd50 : ((sent == 4) ? -32'sd100 : 32'd999);
            end else begin
                iv[1] = 1'b0;
            end
            #1;
            if (ov[1] && !ordy) begin
                check("t4_in_ready_stalled", ir[1], 0);
                if (!just_seen) begin
                    check("t4_hold_data", held_d, $signed(od[1]));
                    check("t4_hold_acc", held_a, oa[1]);
                end
            end
            if (ov[1] && ordy && got < 2) begin
                check("t4_res_acc", oa[1], exp_acc[got]);
                check("t4_res_data", $signed(od[1]), exp_dat[got]);
                got++;
            end
            if (iv[1] && ir[1]) sent++;
        end
        iv[1] = 1'b0;
        ordy  = 1'b1;
        check("t4_beats_taken", sent, 8);
        check("t4_results", got, 2);
        check("t4_stall_seen", seen, 1);
        repeat (3) begin
            @(negedge clk);
            check("t4_no_extra", ov[1], 0);
        end

        // clr mid-group, then a fresh group
        send(1, 7, 1000);
        send(1, 7, 1000);
        clr   = 1'b1;
        iv[1] = 1'b1;
        #1;
        check("t5_clr_blocks_in", ir[1], 0);
        @(negedge clk);
        clr   = 1'b0;
        iv[1] = 1'b0;
        check("t5_ch_cnt_cleared", cc[1], 0);
        check("t5_no_out", ov[1], 0);
        send(1, 100, 50);
        send(1, 100, 12345);
        send(1, 100, 12345);
        send(1, 100, 12345);
        wait_out(1, 3650, 29, "t5_fresh");
        repeat (3) begin
            @(negedge clk);
            check("t5_single_result", ov[1], 0);
        end

        // clr discards a pending, unaccepted result
        ordy = 1'b0;
        send(3, 0, 5);
        n = 0;
        while (!ov[3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_pending", ov[3], 1);
        @(negedge clk);
        check("t7_still_pending", ov[3], 1);
        check("t7_held_data", $signed(od[3]), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t7_clr_drops", ov[3], 0);
        ordy = 1'b1;
        @(negedge clk);
        check("t7_stays_low", ov[3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
